// File: rtl/trace_frame_assembler.sv
// Assembles 8 x 16-bit trace words into 128-bit frames, validates them on commit,
// and buffers good frames in a first-word-fall-through FIFO.
module trace_frame_assembler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic                     traceClkin,
    input  logic                     rst,
    input  logic                     wdAvail,
    input  logic [15:0]              packetWd,
    input  logic                     packetReset,
    input  logic                     packetCommit,
    input  logic                     outReady,
    output logic                     outValid,
    output logic [127:0]             outFrame,
    output logic [$clog2(DEPTH):0]   fifoLevel,
    output logic                     overflow,
    output logic [CNTW-1:0]          dropCount,
    output logic [CNTW-1:0]          badCount
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [15:0]     slot_q [8];
    logic [15:0]     slot_d [8];
    logic [3:0]      idx_q, idx_d;
    logic            bad_q, bad_d;
    logic [127:0]    mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [CNTW-1:0] drop_q, drop_d, badc_q, badc_d;

    logic [127:0]    frame_w;
    logic            pop, push, good_commit;

    assign outValid  = (level_q != '0);
    assign outFrame  = outValid ? mem_q[rd_q] : '0;
    assign fifoLevel = level_q;
    assign overflow  = ovf_q;
    assign dropCount = drop_q;
    assign badCount  = badc_q;

    always_comb begin
        frame_w = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            frame_w[i*16 +: 16] = slot_q[i];
        end
    end

    always_comb begin
        slot_d  = slot_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        badc_d  = badc_q;
        drop_d  = drop_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;

        pop         = outValid && outReady;
        good_commit = packetCommit && !packetReset && (idx_q == 4'd8) && !bad_q;
        // A full FIFO still accepts the frame when the head leaves in the same cycle.
        push        = good_commit && ((level_q != LW'(DEPTH)) || pop);
        ovf_d       = good_commit && !push;

        if (packetReset) begin
            idx_d = '0;
            bad_d = 1'b0;
        end else if (packetCommit) begin
            if (!good_commit && (badc_q != '1)) begin
                badc_d = badc_q + 1'b1;
            end
            bad_d = 1'b0;
            if (wdAvail) begin
                slot_d[0] = packetWd;
                idx_d     = 4'd1;
            end else begin
                idx_d     = '0;
            end
        end else if (wdAvail) begin
            if (idx_q < 4'd8) begin
                slot_d[idx_q[2:0]] = packetWd;
                idx_d              = idx_q + 1'b1;
            end else begin
                bad_d = 1'b1;
            end
        end

        if (ovf_d && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end

        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge traceClkin) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            idx_q   <= '0;
            bad_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            badc_q  <= '0;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            badc_q  <= badc_d;
            if (push) begin
                mem_q[wr_q] <= frame_w;
            end
        end
    end

endmodule

// File: tb/tb_trace_frame_assembler.sv
// Scoreboard bench for trace_frame_assembler: a small model predicts pushed frames,
// observed pops are queued and compared inline by each scenario task.
module tb_trace_frame_assembler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wdAvail;
    logic [15:0]            packetWd;
    logic                   packetReset;
    logic                   packetCommit;
    logic                   outReady;
    logic                   outValid;
    logic [127:0]           outFrame;
    logic [$clog2(DEPTH):0] fifoLevel;
    logic                   overflow;
    logic [CNTW-1:0]        dropCount;
    logic [CNTW-1:0]        badCount;

    trace_frame_assembler #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .traceClkin  (clk),
        .rst         (rst),
        .wdAvail     (wdAvail),
        .packetWd    (packetWd),
        .packetReset (packetReset),
        .packetCommit(packetCommit),
        .outReady    (outReady),
        .outValid    (outValid),
        .outFrame    (outFrame),
        .fifoLevel   (fifoLevel),
        .overflow    (overflow),
        .dropCount   (dropCount),
        .badCount    (badCount)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    logic [15:0]  m_words [8];
    int           m_idx, m_level, m_drop, m_badc, ovf_seen;
    bit           m_bad;

    // Model step + DUT clock edge; inputs must already be driven.
    task automatic cycle();
        bit           m_pop, m_push;
        logic [127:0] f;
        m_pop  = (m_level != 0) && outReady;
        m_push = 1'b0;
        if (outValid === 1'b1 && outReady) got_q.push_back(outFrame);
        if (rst) begin
            m_idx = 0; m_bad = 0; m_level = 0; m_drop = 0; m_badc = 0;
            exp_q.delete();
            m_pop = 1'b0;
        end else if (packetReset) begin
            m_idx = 0; m_bad = 0;
        end else if (packetCommit) begin
            if (m_idx == 8 && !m_bad) begin
                for (int i = 0; i < 8; i++) f[i*16 +: 16] = m_words[i];
                if (m_level < DEPTH || m_pop) begin
                    exp_q.push_back(f);
                    m_push = 1'b1;
                end else begin
                    m_drop++;
                end
            end else begin
                m_badc++;
            end
            m_idx = 0; m_bad = 0;
            if (wdAvail) begin
                m_words[0] = packetWd;
                m_idx = 1;
            end
        end else if (wdAvail) begin
            if (m_idx < 8) begin
                m_words[m_idx] = packetWd;
                m_idx++;
            end else begin
                m_bad = 1;
            end
        end
        if (m_push) m_level++;
        if (m_pop)  m_level--;
        @(posedge clk);
        #1;
        if (overflow === 1'b1) ovf_seen++;
    endtask

    task automatic send_word(input logic [15:0] w);
        wdAvail = 1'b1; packetWd = w;
        cycle();
        wdAvail = 1'b0;
    endtask

    task automatic commit();
        packetCommit = 1'b1;
        cycle();
        packetCommit = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int i = 0; i < 8; i++) send_word(base + 16'(i));
        commit();
    endtask

    task automatic do_reset();
        rst = 1'b1; wdAvail = 0; packetReset = 0; packetCommit = 0; outReady = 0; packetWd = '0;
        cycle(); cycle();
        rst = 1'b0;
        got_q.delete();
        ovf_seen = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({outValid, fifoLevel, overflow, dropCount, badCount} !== '0 || outFrame !== '0) begin
            $display("FAIL reset: valid=%b level=%0d ovf=%b drop=%0d bad=%0d frame=%h, required all zero",
                     outValid, fifoLevel, overflow, dropCount, badCount, outFrame);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [127:0] g, e;
        do_reset();
        outReady = 1'b1;
        send_frame(16'h0001);
        total_cnt++;
        if (outValid !== 1'b1 || outFrame !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
            $display("FAIL basic_frame: valid=%b frame=%h, required 1 / 0008_0007_..._0001", outValid, outFrame);
        end else pass_cnt++;
        cycle();
        total_cnt++;
        if (fifoLevel !== '0 || got_q.size() != 1) begin
            $display("FAIL basic_drain: level=%0d popped=%0d, required 0 / 1", fifoLevel, got_q.size());
        end else pass_cnt++;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++;
            if (g !== e) $display("FAIL basic_sb: got=%h required=%h", g, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_malformed();
        do_reset();
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) send_word(16'h1100 + 16'(i));
        commit();
        total_cnt++;
        if (badCount !== 16'd1 || outValid !== 1'b0) begin
            $display("FAIL short_frame: bad=%0d valid=%b, required 1 / 0", badCount, outValid);
        end else pass_cnt++;
        for (int i = 0; i < 9; i++) send_word(16'h1200 + 16'(i));
        commit();
        total_cnt++;
        if (badCount !== 16'd2 || outValid !== 1'b0 || got_q.size() != 0) begin
            $display("FAIL long_frame: bad=%0d valid=%b popped=%0d, required 2 / 0 / 0",
                     badCount, outValid, got_q.size());
        end else pass_cnt++;
    endtask

    task automatic test_resync();
        logic [127:0] g, e;
        do_reset();
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) send_word(16'h2200 + 16'(i));
        packetReset = 1'b1; wdAvail = 1'b1; packetWd = 16'hDEAD;
        cycle();
        packetReset = 1'b0; wdAvail = 1'b0;
        send_frame(16'h3000);
        cycle();
        total_cnt++;
        if (got_q.size() != 1 || badCount !== '0 || dropCount !== '0) begin
            $display("FAIL resync_count: popped=%0d bad=%0d drop=%0d, required 1 / 0 / 0",
                     got_q.size(), badCount, dropCount);
        end else pass_cnt++;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++;
            if (g !== e || g !== 128'h3007_3006_3005_3004_3003_3002_3001_3000)
                $display("FAIL resync_frame: got=%h required=%h", g, 128'h3007_3006_3005_3004_3003_3002_3001_3000);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        logic [127:0] g, e;
        int n;
        do_reset();
        for (int k = 0; k < DEPTH + 2; k++) send_frame(16'h4000 + 16'(k * 16));
        total_cnt++;
        if (fifoLevel !== 3'(DEPTH) || ovf_seen != 2 || dropCount !== 16'd2) begin
            $display("FAIL overflow: level=%0d pulses=%0d drop=%0d, required %0d / 2 / 2",
                     fifoLevel, ovf_seen, dropCount, DEPTH);
        end else pass_cnt++;
        outReady = 1'b1;
        repeat (DEPTH + 2) cycle();
        total_cnt++;
        if (got_q.size() != DEPTH || fifoLevel !== '0) begin
            $display("FAIL overflow_drain: popped=%0d level=%0d, required %0d / 0",
                     got_q.size(), fifoLevel, DEPTH);
        end else pass_cnt++;
        n = 0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++;
            if (g !== e || g[15:0] !== 16'h4000 + 16'(n * 16))
                $display("FAIL overflow_order[%0d]: got=%h required=%h", n, g, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_full_pop();
        logic [127:0] g, e, last;
        do_reset();
        for (int k = 0; k < DEPTH; k++) send_frame(16'h5000 + 16'(k * 16));
        for (int i = 0; i < 8; i++) send_word(16'h5100 + 16'(i));
        packetCommit = 1'b1; outReady = 1'b1; wdAvail = 1'b1; packetWd = 16'hABCD;
        cycle();
        packetCommit = 1'b0; outReady = 1'b0; wdAvail = 1'b0;
        total_cnt++;
        if (fifoLevel !== 3'(DEPTH) || overflow !== 1'b0 || dropCount !== '0) begin
            $display("FAIL full_pop: level=%0d ovf=%b drop=%0d, required %0d / 0 / 0",
                     fifoLevel, overflow, dropCount, DEPTH);
        end else pass_cnt++;
        for (int i = 1; i < 8; i++) send_word(16'h5200 + 16'(i));
        outReady = 1'b1;
        commit();
        repeat (DEPTH + 1) cycle();
        total_cnt++;
        if (got_q.size() != DEPTH + 2 || fifoLevel !== '0 || ovf_seen != 0) begin
            $display("FAIL full_pop_drain: popped=%0d level=%0d pulses=%0d, required %0d / 0 / 0",
                     got_q.size(), fifoLevel, ovf_seen, DEPTH + 2);
        end else pass_cnt++;
        last = '0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++;
            if (g !== e) $display("FAIL full_pop_sb: got=%h required=%h", g, e);
            else pass_cnt++;
            last = g;
        end
        total_cnt++;
        if (last[15:0] !== 16'hABCD || last[127:112] !== 16'h5207) begin
            $display("FAIL slot0_carry: got=%h, required slot0=abcd slot7=5207", last);
        end else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [127:0] g, e, f;
        do_reset();
        send_frame(16'h6100);
        send_frame(16'h6200);
        for (int i = 0; i < 3; i++) send_word(16'h6300 + 16'(i));
        total_cnt++;
        if (fifoLevel !== 3'd2) begin
            $display("FAIL mid_reset_pre: level=%0d, required 2", fifoLevel);
        end else pass_cnt++;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total_cnt++;
        if ({outValid, fifoLevel, overflow, dropCount, badCount} !== '0 || outFrame !== '0) begin
            $display("FAIL mid_reset: valid=%b level=%0d ovf=%b drop=%0d bad=%0d frame=%h, required all zero",
                     outValid, fifoLevel, overflow, dropCount, badCount, outFrame);
        end else pass_cnt++;
        send_frame(16'h7000);
        outReady = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = 16'h7000 + 16'(i);
        total_cnt++;
        if (got_q.size() != 1 || badCount !== '0) begin
            $display("FAIL mid_reset_post: popped=%0d bad=%0d, required 1 / 0", got_q.size(), badCount);
        end else pass_cnt++;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++;
            if (g !== e || g !== f) $display("FAIL mid_reset_frame: got=%h required=%h", g, f);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; wdAvail = 0; packetWd = '0; packetReset = 0; packetCommit = 0; outReady = 0;
        m_idx = 0; m_bad = 0; m_level = 0; m_drop = 0; m_badc = 0; ovf_seen = 0;
        test_reset();
        test_basic();
        test_malformed();
        test_resync();
        test_overflow();
        test_full_pop();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
